// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage decode results in, stall/forwarding controls out
interface hazard_scoreboard_if #(
    parameter int TW   = 2,
    parameter int SELW = 2
);
    logic            flush;
    logic [4:0]      d_rs;
    logic [4:0]      d_rt;
    logic            d_rs_used;
    logic            d_rt_used;
    logic [TW-1:0]   d_rs_tuse;
    logic [TW-1:0]   d_rt_tuse;
    logic [4:0]      d_a3;
    logic            d_regwrite;
    logic [TW-1:0]   d_tnew;
    logic            d_md_start;
    logic            d_md_div;
    logic            d_md_use;
    logic            stall;
    logic [SELW-1:0] d_fwd_rs_sel;
    logic [SELW-1:0] d_fwd_rt_sel;
    logic [SELW-1:0] e_fwd_rs_sel;
    logic [SELW-1:0] e_fwd_rt_sel;
    logic            md_busy;

    modport master (
        output flush, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
               d_a3, d_regwrite, d_tnew, d_md_start, d_md_div, d_md_use,
        input  stall, d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel, md_busy
    );

    modport slave (
        input  flush, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
               d_a3, d_regwrite, d_tnew, d_md_start, d_md_div, d_md_use,
        output stall, d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer scoreboard producing D stall and D/E forwarding selects
module hazard_scoreboard #(
    parameter int STAGES      = 3,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int SELW        = $clog2(STAGES + 1)
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hs
);
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic            hit;
        logic [SELW-1:0] stage;
        logic [TW-1:0]   tnew;
    } match_t;

    logic [STAGES:1] valid_q, valid_d;
    logic [4:0]      a3_q   [1:STAGES];
    logic [4:0]      a3_d   [1:STAGES];
    logic [TW-1:0]   tnew_q [1:STAGES];
    logic [TW-1:0]   tnew_d [1:STAGES];
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rt1_q, rt1_d;
    logic            md_start1_q, md_start1_d;
    logic            md_div1_q, md_div1_d;
    logic [CW-1:0]   md_cnt_q, md_cnt_d;

    match_t d_rs_m, d_rt_m, e_rs_m, e_rt_m;
    logic   rs_stall, rt_stall, md_stall, stall_c, md_busy_c;

    // Scanned oldest to youngest so the lowest matching stage overrides.
    function automatic match_t youngest(input logic [4:0] r, input int first);
        match_t m;
        m = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (k >= first && r != 5'd0 && valid_q[k] && a3_q[k] == r) begin
                m.hit   = 1'b1;
                m.stage = SELW'(k);
                m.tnew  = tnew_q[k];
            end
        end
        return m;
    endfunction

    always_comb begin
        d_rs_m = youngest(hs.d_rs, 1);
        d_rt_m = youngest(hs.d_rt, 1);
        e_rs_m = youngest(rs1_q, 2);
        e_rt_m = youngest(rt1_q, 2);

        rs_stall  = hs.d_rs_used && d_rs_m.hit && (d_rs_m.tnew > hs.d_rs_tuse);
        rt_stall  = hs.d_rt_used && d_rt_m.hit && (d_rt_m.tnew > hs.d_rt_tuse);
        md_busy_c = (md_cnt_q != '0);
        md_stall  = hs.d_md_use && (md_busy_c || md_start1_q);
        stall_c   = (rs_stall || rt_stall || md_stall) && !hs.flush;
    end

    assign hs.stall        = stall_c;
    assign hs.md_busy      = md_busy_c;
    assign hs.d_fwd_rs_sel = (hs.d_rs_used && d_rs_m.hit && d_rs_m.tnew == '0) ? d_rs_m.stage : '0;
    assign hs.d_fwd_rt_sel = (hs.d_rt_used && d_rt_m.hit && d_rt_m.tnew == '0) ? d_rt_m.stage : '0;
    assign hs.e_fwd_rs_sel = (e_rs_m.hit && e_rs_m.tnew == '0) ? e_rs_m.stage : '0;
    assign hs.e_fwd_rt_sel = (e_rt_m.hit && e_rt_m.tnew == '0) ? e_rt_m.stage : '0;

    // Entry 1 takes the D instruction unless stalled; older entries always age.
    always_comb begin
        valid_d = valid_q;
        a3_d    = a3_q;
        tnew_d  = tnew_q;

        valid_d[1]  = !stall_c && hs.d_regwrite && (hs.d_a3 != 5'd0);
        a3_d[1]     = stall_c ? 5'd0 : hs.d_a3;
        tnew_d[1]   = stall_c ? '0 : hs.d_tnew;
        rs1_d       = (!stall_c && hs.d_rs_used) ? hs.d_rs : 5'd0;
        rt1_d       = (!stall_c && hs.d_rt_used) ? hs.d_rt : 5'd0;
        md_start1_d = !stall_c && hs.d_md_start;
        md_div1_d   = !stall_c && hs.d_md_start && hs.d_md_div;

        for (int k = 2; k <= STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a3_d[k]    = a3_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end

        if (hs.flush) begin
            valid_d     = '0;
            rs1_d       = 5'd0;
            rt1_d       = 5'd0;
            md_start1_d = 1'b0;
            md_div1_d   = 1'b0;
        end

        // The mult/div unit keeps running across a flush.
        if (md_start1_q) begin
            md_cnt_d = md_div1_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            rs1_q       <= 5'd0;
            rt1_q       <= 5'd0;
            md_start1_q <= 1'b0;
            md_div1_q   <= 1'b0;
            md_cnt_q    <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= 5'd0;
                tnew_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rt1_q       <= rt1_d;
            md_start1_q <= md_start1_d;
            md_div1_q   <= md_div1_d;
            md_cnt_q    <= md_cnt_d;
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= a3_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vectors for hazard_scoreboard
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.TW(2), .SELW(2)) hs ();
    hazard_scoreboard_if #(.TW(2), .SELW(2)) hs3 ();

    hazard_scoreboard #(.STAGES(3), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .hs(hs.slave)
    );
    hazard_scoreboard #(.STAGES(3), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .hs(hs3.slave)
    );

    assign hs3.flush      = hs.flush;
    assign hs3.d_rs       = hs.d_rs;
    assign hs3.d_rt       = hs.d_rt;
    assign hs3.d_rs_used  = hs.d_rs_used;
    assign hs3.d_rt_used  = hs.d_rt_used;
    assign hs3.d_rs_tuse  = hs.d_rs_tuse;
    assign hs3.d_rt_tuse  = hs.d_rt_tuse;
    assign hs3.d_a3       = hs.d_a3;
    assign hs3.d_regwrite = hs.d_regwrite;
    assign hs3.d_tnew     = hs.d_tnew;
    assign hs3.d_md_start = hs.d_md_start;
    assign hs3.d_md_div   = hs.d_md_div;
    assign hs3.d_md_use   = hs.d_md_use;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_d(input logic [4:0] rs, input logic rs_used, input logic [1:0] rs_tuse,
                           input logic [4:0] rt, input logic rt_used, input logic [1:0] rt_tuse,
                           input logic [4:0] a3, input logic regwrite, input logic [1:0] tnew,
                           input logic md_start, input logic md_div, input logic md_use);
        hs.d_rs = rs;  hs.d_rs_used = rs_used;  hs.d_rs_tuse = rs_tuse;
        hs.d_rt = rt;  hs.d_rt_used = rt_used;  hs.d_rt_tuse = rt_tuse;
        hs.d_a3 = a3;  hs.d_regwrite = regwrite; hs.d_tnew = tnew;
        hs.d_md_start = md_start; hs.d_md_div = md_div; hs.d_md_use = md_use;
    endtask

    task automatic d_nop();
        drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    int st_cnt, st3_cnt, busy_cnt, busy3_cnt;

    initial begin
        reset = 1'b1;
        hs.flush = 1'b0;
        d_nop();
        advance();
        advance();
        reset = 1'b0;

        // add $3,$1,$2 with nothing in flight
        drive_d(1, 1, 1, 2, 1, 1, 3, 1, 1, 0, 0, 0);
        settle();
        check("idle_stall", hs.stall, 0);
        check("idle_d_rs_sel", hs.d_fwd_rs_sel, 0);
        check("idle_d_rt_sel", hs.d_fwd_rt_sel, 0);
        check("idle_e_rs_sel", hs.e_fwd_rs_sel, 0);
        check("idle_e_rt_sel", hs.e_fwd_rt_sel, 0);
        check("idle_md_busy", hs.md_busy, 0);
        advance();
        d_nop();
        advance(); advance(); advance();

        // lw $5 then add $6,$5,$0
        drive_d(29, 1, 1, 0, 0, 0, 5, 1, 2, 0, 0, 0);
        advance();
        drive_d(5, 1, 1, 0, 1, 1, 6, 1, 1, 0, 0, 0);
        settle();
        check("lw_use_stall_c1", hs.stall, 1);
        advance();
        settle();
        check("lw_use_stall_c2", hs.stall, 0);
        check("lw_use_d_rs_sel_c2", hs.d_fwd_rs_sel, 0);
        advance();
        d_nop();
        settle();
        check("lw_use_e_rs_sel_c3", hs.e_fwd_rs_sel, 3);
        check("lw_use_e_rt_sel_c3", hs.e_fwd_rt_sel, 0);
        advance();
        advance(); advance();

        // addu $4 then beq $4,$0
        drive_d(1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 0, 0);
        advance();
        drive_d(4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("beq_stall_c1", hs.stall, 1);
        advance();
        settle();
        check("beq_stall_c2", hs.stall, 0);
        check("beq_d_rs_sel_c2", hs.d_fwd_rs_sel, 2);
        advance();
        d_nop();
        advance(); advance(); advance();

        // two writers of $7 in M and W, ori $8,$7 in D
        drive_d(1, 1, 1, 2, 1, 1, 7, 1, 1, 0, 0, 0);
        advance();
        drive_d(2, 1, 1, 3, 1, 1, 7, 1, 1, 0, 0, 0);
        advance();
        d_nop();
        advance();
        drive_d(7, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        settle();
        check("youngest_stall", hs.stall, 0);
        check("youngest_d_rs_sel", hs.d_fwd_rs_sel, 2);
        advance();

        // writer of $0 followed by a $0 reader with tuse 0
        drive_d(1, 1, 1, 2, 1, 1, 0, 1, 1, 0, 0, 0);
        advance();
        drive_d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("zero_src_stall", hs.stall, 0);
        check("zero_src_d_rs_sel", hs.d_fwd_rs_sel, 0);
        check("zero_src_d_rt_sel", hs.d_fwd_rt_sel, 0);
        advance();
        d_nop();
        advance(); advance(); advance();

        // div then mflo, counted on both DIV_CYCLES variants
        drive_d(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 1);
        settle();
        check("div_issue_stall", hs.stall, 0);
        advance();
        drive_d(0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1);
        st_cnt = 0; st3_cnt = 0; busy_cnt = 0; busy3_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            settle();
            st_cnt    += int'(hs.stall);
            st3_cnt   += int'(hs3.stall);
            busy_cnt  += int'(hs.md_busy);
            busy3_cnt += int'(hs3.md_busy);
            advance();
        end
        check("div10_stall_cycles", st_cnt, 11);
        check("div10_busy_cycles", busy_cnt, 10);
        check("div3_stall_cycles", st3_cnt, 4);
        check("div3_busy_cycles", busy3_cnt, 3);
        d_nop();
        advance(); advance(); advance();

        // mult, lw $5, add $6,$5 then flush while stalled
        drive_d(1, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
        settle();
        check("mult_issue_stall", hs.stall, 0);
        advance();
        drive_d(29, 1, 1, 0, 0, 0, 5, 1, 2, 0, 0, 0);
        advance();
        drive_d(5, 1, 1, 0, 1, 1, 6, 1, 1, 0, 0, 0);
        settle();
        check("flush_pre_stall", hs.stall, 1);
        hs.flush = 1'b1;
        #1;
        check("flush_forces_stall_low", hs.stall, 0);
        advance();
        hs.flush = 1'b0;
        settle();
        check("post_flush_stall", hs.stall, 0);
        check("post_flush_d_rs_sel", hs.d_fwd_rs_sel, 0);
        check("post_flush_e_rs_sel", hs.e_fwd_rs_sel, 0);
        check("post_flush_md_busy", hs.md_busy, 1);

        // mflo while busy, then reset mid-busy
        advance();
        drive_d(0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1);
        settle();
        check("busy_mflo_stall", hs.stall, 1);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        check("reset_md_busy", hs.md_busy, 0);
        check("reset_stall", hs.stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It consumes the per-instruction decode results produced in D: register addresses, Tuse, Tnew, write enable and mult/div start. It keeps a scoreboard shift register of in-flight writers for E..W and a mult/div busy counter. From these it generates the D-stage stall and the forwarding selects for D and E operand reads.

## Interface
Parameters:
- STAGES, 3, scoreboard depth after D (1=E, 2=M, 3=W); ≥2
- TW, 2, width of Tuse/Tnew fields
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- SELW, $clog2(STAGES+1), forwarding select width

Ports:
- clk  in  1  clock. One clock domain, rising edge.
- reset  in  1  synchronous, active-high
- flush  in  1  exception/eret flush; clears the scoreboard
- d_rs, d_rt  in  5 each  D-stage source registers
- d_rs_used, d_rt_used  in  1 each  source is actually read (Tuse valid)
- d_rs_tuse, d_rt_tuse  in  TW each  Tuse of each source
- d_a3  in  5  destination register
- d_regwrite  in  1  instruction writes GRF
- d_tnew  in  TW  Tnew as seen on entry to E
- d_md_start  in  1  instruction is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: selects DIV_CYCLES
- d_md_use  in  1  instruction reads/writes HI/LO or starts mult/div
- stall  out  1  freeze PC and the D register; insert a bubble into E
- d_fwd_rs_sel, d_fwd_rt_sel  out  SELW each  0 = GRF value, k = result of stage k
- e_fwd_rs_sel, e_fwd_rt_sel  out  SELW each  same encoding, for E-stage operands (k≥2)
- md_busy  out  1  mult/div unit busy

## Operation
Each scoreboard entry k holds:
- valid, a3, tnew, rs, rt (the last two are used at stage 1 only)
- md_start (stage 1 only)

A valid entry with a3==0 or regwrite=0 is stored as invalid.

Edge update, in priority order:
- reset: all entries invalid; counter=0.
- flush: all entries invalid. The counter is untouched, because an in-flight mult/div completes.
- Otherwise:
  - entry[1] ← bubble if stall, else D fields (tnew=d_tnew, md_start=d_md_start).
  - entry[k] ← entry[k-1] for k≥2, with tnew decremented and saturating at 0.

Match rule for source r at stage k: r≠0, entry[k] valid, entry[k].a3==r. Only the youngest matching stage (lowest k) is considered.

D source r (when used):
- Youngest match has tnew > tuse → stall request.
- Youngest match has tnew == 0 → d_fwd_sel = k.
- Otherwise → sel 0. The value is deferred to E forwarding.

Unused sources never stall, and their sel is 0.

E source (entry[1].rs/rt vs stages 2..STAGES): youngest match with tnew==0 → e_fwd_sel = k, else 0.

Mult/div counter:
- At an edge where entry[1].md_start is set (and no reset), the counter loads DIV_CYCLES if that instruction was a div, else MULT_CYCLES.
- Otherwise the counter decrements if nonzero.
- md_busy = counter≠0.

stall = any D-source stall request | (d_md_use & (md_busy | entry[1].md_start)).

All outputs are combinational from the scoreboard state plus D inputs. When flush is high, stall is forced to 0.

## Timing
- After reset: stall=0, all sels=0, md_busy=0.
- lw in E (Tnew 2) vs add in D using rs (Tuse 1) → stall 1 cycle.
- Next cycle, lw in M (tnew 1): no stall; rs is forwarded at E from stage 3 on the following cycle.
- Mult issued at edge t (enters E): a dependent mfhi in D stalls during cycle t and for MULT_CYCLES further cycles. It issues at the first edge with md_busy=0.
- Simultaneous flush and stall: flush wins; entry[1] becomes a bubble.
- Reset mid-busy clears the counter immediately.
- Stall does not alter the shift of entries 2..STAGES.

## Test plan
- After reset, feed add $3,$1,$2 with no writers in flight → stall=0, all sels=0, md_busy=0.
- lw $5 (tnew 2), then add $6,$5,$0 (rs_tuse 1):
  - cycle 1: stall=1.
  - cycle 2: stall=0, d_fwd_rs_sel=0.
  - cycle 3: e_fwd_rs_sel=3.
- addu $4 followed by beq $4 (tuse 0): stall=1 for 1 cycle, then d_fwd_rs_sel=2 (tnew 0 in M).
- Two writers to $7 in M and W, with ori $8,$7 in D → selects the youngest stage (M); $0 as source → never stalls or forwards.
- div then mflo: stall=1 for 1+DIV_CYCLES cycles; md_busy high for exactly 10 cycles; with DIV_CYCLES=3 the count scales to 3.
- Flush while lw is in E and stall=1 → next cycle: no stall, scoreboard empty; md_busy unaffected.
- Reset asserted mid-busy → next cycle: md_busy=0, stall=0.
